// File: rtl/gauss_sa_ctrl_pkg.sv
// Shared types and defaults for the Gauss systolic-array controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gauss_sa_ctrl_pkg;

  localparam int DAT_W_DEF   = 4;
  localparam int ROWS_DEF    = 2;
  localparam int TIMEOUT_DEF = 64;

  // Wait counter must be able to hold TIMEOUT itself.
  localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    WAIT,
    COLLECT,
    OUT
  } state_t;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/gauss_sa_rowbuf.sv
// ROWS x DAT_W register file: one synchronous write port, one async read port.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none, writes always accepted.
module gauss_sa_rowbuf
  import gauss_sa_ctrl_pkg::*;
#(
  parameter int DAT_W = DAT_W_DEF,
  parameter int ROWS  = ROWS_DEF
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_addr,
  input  logic [DAT_W-1:0]        wr_data,
  input  logic [$clog2(ROWS)-1:0] rd_addr,
  output logic [DAT_W-1:0]        rd_data
);

  logic [DAT_W-1:0] mem [ROWS];

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gauss_sa_ctrl.sv
// Sequences a command through the array: feeds ROWS rows, waits for finish, streams results.
// Latency: first row on sa_data 1 cycle after accept; first result 2 cycles after sa_finish.
// Backpressure: res_ready stalls the result stream; cmd_ready low whenever not IDLE.
module gauss_sa_ctrl
  import gauss_sa_ctrl_pkg::*;
#(
  parameter int DAT_W   = DAT_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    row_wr_en,
  input  logic [$clog2(ROWS)-1:0] row_wr_addr,
  input  logic [DAT_W-1:0]        row_wr_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_mode,
  input  logic [ROWS-1:0]         cmd_swap,
  output logic                    sa_mode,
  output logic                    sa_start,
  output logic                    sa_swap,
  output logic [DAT_W-1:0]        sa_data,
  input  logic                    sa_finish,
  input  logic                    sa_full_rank,
  input  logic [DAT_W-1:0]        sa_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DAT_W-1:0]        res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic                    done,
  output logic                    rank_ok,
  output logic                    timeout_err
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     idx;       // feed row index, then collect index
  logic [AW-1:0]     j;         // output index
  logic [CW-1:0]     cnt;       // cycles spent in WAIT
  logic [ROWS-1:0]   swap_reg;
  logic              row_we;
  logic              res_we;
  logic [AW-1:0]     res_waddr;
  logic [DAT_W-1:0]  row_rd;
  logic [DAT_W-1:0]  res_rd;

  // Rows may only be rewritten while no run is in flight.
  assign row_we    = row_wr_en && (state == IDLE);
  // res_buf[0] is taken on the finish cycle, the rest on the following COLLECT cycles.
  assign res_we    = ((state == WAIT) && sa_finish) || (state == COLLECT);
  assign res_waddr = (state == WAIT) ? '0 : idx;

  gauss_sa_rowbuf #(.DAT_W(DAT_W), .ROWS(ROWS)) u_row_buf (
    .clk     (clk),
    .wr_en   (row_we),
    .wr_addr (row_wr_addr),
    .wr_data (row_wr_data),
    .rd_addr (idx),
    .rd_data (row_rd)
  );

  gauss_sa_rowbuf #(.DAT_W(DAT_W), .ROWS(ROWS)) u_res_buf (
    .clk     (clk),
    .wr_en   (res_we),
    .wr_addr (res_waddr),
    .wr_data (sa_result),
    .rd_addr (j),
    .rd_data (res_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and state-decoded outputs; array and result outputs are zero outside their phase.
  always_comb begin
    state_nx  = state;
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    sa_start  = 1'b0;
    sa_swap   = 1'b0;
    sa_data   = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_last  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nx = FEED;
      end
      FEED: begin
        sa_start = (idx == '0);
        sa_swap  = swap_reg[idx];
        sa_data  = row_rd;
        if (idx == LAST_ROW) state_nx = WAIT;
      end
      WAIT: begin
        // A finish landing on the timeout cycle still wins.
        if (sa_finish)            state_nx = COLLECT;
        else if (cnt == CNT_MAX)  state_nx = IDLE;
      end
      COLLECT: begin
        if (idx == LAST_ROW) state_nx = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        res_data  = res_rd;
        res_last  = (j == LAST_ROW);
        if (res_ready && (j == LAST_ROW)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Indices, wait counter, latched command fields and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      j           <= '0;
      cnt         <= '0;
      swap_reg    <= '0;
      sa_mode     <= 1'b0;
      done        <= 1'b0;
      rank_ok     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sa_mode     <= cmd_mode;
            swap_reg    <= cmd_swap;
            rank_ok     <= 1'b0;
            timeout_err <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
            j           <= '0;
          end
        end
        FEED: begin
          idx <= (idx == LAST_ROW) ? '0 : idx + AW'(1);
          cnt <= '0;
        end
        WAIT: begin
          if (sa_finish) begin
            rank_ok <= sa_full_rank;
            idx     <= AW'(1);
          end else if (cnt == CNT_MAX) begin
            timeout_err <= 1'b1;
            rank_ok     <= 1'b0;
            done        <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        COLLECT: begin
          idx <= (idx == LAST_ROW) ? '0 : idx + AW'(1);
          j   <= '0;
        end
        OUT: begin
          if (res_ready) begin
            if (j == LAST_ROW) begin
              j    <= '0;
              done <= 1'b1;
            end else begin
              j <= j + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_sa_ctrl.sv
// Self-checking bench for gauss_sa_ctrl: table of runs plus hand-written corner sequences.
// A small array model answers each feed; a scoreboard checks the result stream.
// Inputs change at negedge or 1 ns after posedge; outputs are checked away from posedge.
module tb_gauss_sa_ctrl;

  localparam int DW  = 4;
  localparam int R   = 2;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          row_wr_en = 1'b0;
  logic [0:0]    row_wr_addr = '0;
  logic [DW-1:0] row_wr_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic [R-1:0]  cmd_swap = '0;
  logic          sa_mode, sa_start, sa_swap;
  logic [DW-1:0] sa_data;
  logic          sa_finish = 1'b0;
  logic          sa_full_rank = 1'b0;
  logic [DW-1:0] sa_result = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          res_last, busy, done, rank_ok, timeout_err;

  gauss_sa_ctrl #(.DAT_W(DW), .ROWS(R), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .row_wr_en(row_wr_en), .row_wr_addr(row_wr_addr), .row_wr_data(row_wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_swap(cmd_swap),
    .sa_mode(sa_mode), .sa_start(sa_start), .sa_swap(sa_swap), .sa_data(sa_data),
    .sa_finish(sa_finish), .sa_full_rank(sa_full_rank), .sa_result(sa_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .rank_ok(rank_ok), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0][DW-1:0] rows;
    logic                 mode;
    logic [R-1:0]         swap;
    logic [R-1:0][DW-1:0] res;
    logic                 fr;
    logic [R-1:0][DW-1:0] exp_d;
    logic [R-1:0]         exp_sw;
    logic                 exp_rank;
    int                   stall;
    bit                   bw;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  vec_t tbl [4];
  exp_t sb [$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // array model and monitor state
  bit                   m_en = 1'b0;
  int                   m_delay = 5;
  int                   m_cnt = 0;
  int                   m_k = 0;
  logic [R-1:0][DW-1:0] m_res = '0;
  logic                 m_fr = 1'b0;
  bit                   force_fin = 1'b0;
  int                   stall_left = 0;
  int                   valid_cycles = 0;
  int                   first_valid = -1;
  int                   last_hs = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                              input logic m, input logic [R-1:0] sw,
                              input logic [DW-1:0] q0, input logic [DW-1:0] q1, input logic fr,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic es0, input logic es1, input logic er,
                              input int st, input bit bw);
    vec_t v;
    v.rows[0] = r0;  v.rows[1] = r1;
    v.mode = m;      v.swap = sw;
    v.res[0] = q0;   v.res[1] = q1;   v.fr = fr;
    v.exp_d[0] = e0; v.exp_d[1] = e1;
    v.exp_sw[0] = es0; v.exp_sw[1] = es1;
    v.exp_rank = er; v.stall = st; v.bw = bw;
    return v;
  endfunction

  // One clock: at negedge drive the array model and res_ready and check the result port,
  // then return 1 ns after the next posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    sa_finish = force_fin;
    sa_full_rank = 1'b0;
    sa_result = '0;
    if (m_k > 0 && m_k < R) begin
      sa_result = m_res[m_k];
      m_k++;
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        sa_finish = 1'b1;
        sa_full_rank = m_fr;
        sa_result = m_res[0];
        m_k = 1;
        for (int k = 0; k < R; k++) begin
          e.d = m_res[k];
          e.last = (k == R - 1);
          sb.push_back(e);
        end
      end
    end
    // finish arrives m_delay cycles after the last fed row
    if (m_en && sa_start) m_cnt = R - 1 + m_delay;
    res_ready = 1'b1;
    if (res_valid && stall_left > 0) begin
      res_ready = 1'b0;
      stall_left--;
    end
    if (res_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      if (sb.size() == 0) begin
        chk("res_unexpected", res_valid, 0);
      end else if (res_ready) begin
        e = sb.pop_front();
        chk("res_data", res_data, e.d);
        chk("res_last", res_last, e.last);
        if (e.last) last_hs = cyc;
      end else begin
        chk("res_hold", res_data, sb[0].d);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_rows(input vec_t v);
    for (int i = 0; i < R; i++) begin
      row_wr_en = 1'b1;
      row_wr_addr = 1'(i);
      row_wr_data = v.rows[i];
      step();
    end
    row_wr_en = 1'b0;
  endtask

  // Present a command at cycle t and check the feed cycles t+1..t+R and the cycle after.
  task automatic cmd_and_feed(input vec_t v, input bit bw, output int t);
    cmd_valid = 1'b1;
    cmd_mode = v.mode;
    cmd_swap = v.swap;
    chk("cmd_ready", cmd_ready, 1);
    t = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_swap = '0;
    for (int i = 0; i < R; i++) begin
      chk("sa_start", sa_start, (i == 0));
      chk("sa_data", sa_data, v.exp_d[i]);
      chk("sa_swap", sa_swap, v.exp_sw[i]);
      chk("sa_mode", sa_mode, v.mode);
      if (i == 0) begin
        chk("busy", busy, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("rank_cleared", rank_ok, 0);
        chk("tmo_cleared", timeout_err, 0);
        chk("done_one_cycle", done, 0);
      end
      if (bw) begin
        row_wr_en = 1'b1;
        row_wr_addr = 1'(i);
        row_wr_data = ~v.rows[i];
      end
      step();
    end
    row_wr_en = 1'b0;
    chk("sa_start_after", sa_start, 0);
    chk("sa_data_after", sa_data, 0);
    chk("sa_swap_after", sa_swap, 0);
    chk("sa_mode_after", sa_mode, v.mode);
  endtask

  task automatic wait_done(output int dc);
    for (int i = 0; i < 400 && !done; i++) step();
    chk("done_seen", done, 1);
    dc = cyc;
  endtask

  // Full run ending in the done cycle. From accept at t: feed t+1..t+R, finish at
  // t+R+delay, first result two cycles later, done one cycle after the last handshake.
  task automatic run(input vec_t v, input bit wr, input bit bw, input int stall, input int delay);
    int t;
    int dc;
    if (wr) load_rows(v);
    m_en = 1'b1;
    m_delay = delay;
    m_res = v.res;
    m_fr = v.fr;
    stall_left = stall;
    valid_cycles = 0;
    first_valid = -1;
    last_hs = -1;
    cmd_and_feed(v, bw, t);
    wait_done(dc);
    chk("first_valid", first_valid - t, R + delay + 2);
    chk("done_cycle", dc - t, R + delay + 2 + R + stall);
    chk("done_after_last", dc - last_hs, 1);
    chk("valid_cycles", valid_cycles, R + stall);
    chk("rank_ok", rank_ok, v.exp_rank);
    chk("timeout_err", timeout_err, 0);
    chk("sa_mode_hold", sa_mode, v.mode);
    chk("sb_drained", sb.size(), 0);
    m_en = 1'b0;
  endtask

  initial begin
    int t;
    int dc;

    //            row0     row1     mode swap   res0     res1     fr  exp_d0   exp_d1   sw0 sw1 rank stall bw
    tbl[0] = mk(4'b1010, 4'b0110, 1'b0, 2'b00, 4'b1000, 4'b0100, 1'b1, 4'b1010, 4'b0110, 0, 0, 1'b1, 0, 0);
    tbl[1] = mk(4'b1010, 4'b0110, 1'b0, 2'b00, 4'b1000, 4'b0100, 1'b1, 4'b1010, 4'b0110, 0, 0, 1'b1, 3, 0);
    tbl[2] = mk(4'b1111, 4'b0001, 1'b1, 2'b10, 4'b0011, 4'b1100, 1'b0, 4'b1111, 4'b0001, 0, 1, 1'b0, 0, 0);
    tbl[3] = mk(4'b0011, 4'b1100, 1'b0, 2'b01, 4'b1001, 4'b0110, 1'b1, 4'b0011, 4'b1100, 1, 0, 1'b1, 0, 1);

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rank", rank_ok, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sa_mode", sa_mode, 0);
    chk("rst_sa_start", sa_start, 0);
    rst = 1'b0;
    step();

    // table of runs: basic feed/result, stalled output, mode/swap, writes while busy
    for (int i = 0; i < 4; i++) begin
      run(tbl[i], 1'b1, tbl[i].bw, tbl[i].stall, 5);
    end

    // command in the done cycle is accepted; rows unchanged by the writes made while busy
    run(tbl[3], 1'b0, 1'b0, 0, 5);

    // no finish: timeout after the counter reaches TMO in WAIT (WAIT starts at t+3)
    m_en = 1'b0;
    valid_cycles = 0;
    cmd_and_feed(tbl[3], 1'b0, t);
    wait_done(dc);
    chk("tmo_done_cycle", dc - t, 3 + TMO + 1);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_rank", rank_ok, 0);
    chk("tmo_no_valid", valid_cycles, 0);
    chk("tmo_idle", cmd_ready, 1);

    // stray finish while idle is ignored; timeout_err stays set
    force_fin = 1'b1;
    step();
    step();
    force_fin = 1'b0;
    chk("stray_fin_busy", busy, 0);
    chk("stray_fin_valid", valid_cycles, 0);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_done_once", done, 0);

    // next command clears timeout_err
    run(tbl[3], 1'b0, 1'b0, 0, 5);

    // finish on the very cycle the counter hits TMO is a finish
    run(tbl[3], 1'b0, 1'b0, 0, TMO + 1);

    // reset in the middle of FEED
    load_rows(tbl[2]);
    cmd_valid = 1'b1;
    cmd_mode = tbl[2].mode;
    cmd_swap = tbl[2].swap;
    step();
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_swap = '0;
    chk("mid_feed_start", sa_start, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_sa_mode", sa_mode, 0);
    chk("mrst_sa_start", sa_start, 0);
    chk("mrst_sa_swap", sa_swap, 0);
    chk("mrst_sa_data", sa_data, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_last", res_last, 0);
    chk("mrst_res_data", res_data, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rank", rank_ok, 0);
    chk("mrst_tmo", timeout_err, 0);
    m_cnt = 0;
    sb.delete();
    step();

    // recovery after reset, rows kept across reset
    run(tbl[2], 1'b0, 1'b0, 0, 5);
    step();
    chk("final_done_low", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
